// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the control decoder.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: magnitudes are processed for ITER
// cycles in a shared 65-bit accumulator, then sign-corrected in one FIX cycle.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITER  = muldiv_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             dz
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITER);

  // Handshake: start is sampled only in S_IDLE; busy stays high from the start
  // edge until the FIX edge, which also raises done for exactly one cycle.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_orig;
  op_t              op_q;
  logic             sa, sb, bz;

  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_next, shl, div_next;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo, rem, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_signed = op[0];
    is_div    = op[1];
    a_neg     = is_signed & A[WIDTH-1];
    b_neg     = is_signed & B[WIDTH-1];
    mag_a     = a_neg ? -A : A;
    mag_b     = b_neg ? -B : B;

    // Multiply step: conditional add into the upper half, carry kept in bit 2W.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? ({mul_sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);

    // Restoring divide step on {rem,quo}; the remainder never exceeds W bits.
    shl      = {acc[2*WIDTH-1:0], 1'b0};
    diff     = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, opnd};
    div_next = diff[WIDTH+1] ? shl : {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};

    prod = acc[2*WIDTH-1:0];
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
      if (bz) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_lo = (sa ^ sb) ? -quo : quo;
        fix_hi = sa ? -rem : rem;
      end
    end else begin
      {fix_hi, fix_lo} = (sa ^ sb) ? -prod : prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      op_q   <= OP_MULTU;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op_t'(op);
            sa     <= a_neg;
            sb     <= b_neg;
            bz     <= (B == '0);
            a_orig <= A;
            opnd   <= is_div ? mag_b : mag_a;
            acc    <= {{(WIDTH+1){1'b0}}, (is_div ? mag_a : mag_b)};
            cnt    <= CW'(ITER - 1);
            busy   <= 1'b1;
            state  <= S_CALC;
          end else begin
            if (hi_we) HI <= w_data;
            if (lo_we) LO <= w_data;
          end
        end
        S_CALC: begin
          acc <= op_q[1] ? div_next : mul_next;
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          dz    <= op_q[1] & bz;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: expected {HI,LO,dz} are queued at launch and
// compared when done pulses.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] w_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  logic [64:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic        seen;
  logic [1:0]  ro;
  logic [31:0] rx, ry;

  // clock / reset
  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .hi_we(hi_we), .lo_we(lo_we), .w_data(w_data),
    .HI(hi), .LO(lo), .busy(busy), .done(done), .dz(dz)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: {HI, LO, dz}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] p;
    logic [31:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULTU: p = {32'b0, x} * {32'b0, y};
      OP_MULT:  p = 64'(sx * sy);
      default:  p = '0;
    endcase
    if (o[1] == 1'b0) return {p, 1'b0};
    if (y == 32'd0) return {x, 32'hFFFF_FFFF, 1'b1};
    if (o == OP_DIVU) begin
      q = x / y;
      r = x % y;
    end else begin
      q = 32'(sx / sy);
      r = 32'(sx % sy);
    end
    return {r, q, 1'b0};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit track);
    if (track) exp_q.push_back(model(o, x, y));
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_start", 65'(busy), 65'(1));
  endtask

  task automatic wait_done(input string tag);
    logic [64:0] e;
    while (!done && cyc < 40) step();
    check({tag, "_latency"}, 65'(cyc), 65'(33));
    check({tag, "_busy_cycles"}, 65'(busy_cnt), 65'(33));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_result"}, {hi, lo, dz}, e);
    check({tag, "_busy_low"}, 65'(busy), 65'(0));
    step();
    check({tag, "_done_1cyc"}, 65'(done), 65'(0));
  endtask

  initial begin
    #1;
    check("rst_hi", 65'(hi), 65'(0));
    check("rst_lo", 65'(lo), 65'(0));
    check("rst_flags", 65'({busy, done, dz}), 65'(0));
    @(negedge clk);
    rst = 1'b0;
    step();

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("multu_max");
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);          wait_done("mult_neg");
    launch(OP_DIVU, 32'd100, 32'd7, 1'b1);                wait_done("divu_100_7");
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_done("div_neg");
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_done("div_ovf");
    launch(OP_DIVU, 32'd5, 32'd0, 1'b1);                  wait_done("divu_zero");
    launch(OP_MULTU, 32'd2, 32'd3, 1'b1);                 wait_done("dz_clear");

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 5) ? 32'd1 : $urandom;
      launch(ro, rx, ry, 1'b1);
      wait_done("rand");
    end

    // start and MTLO/MTHI while busy must be ignored
    launch(OP_MULTU, 32'd3, 32'd4, 1'b1);
    repeat (9) step();
    op = OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    lo_we = 1'b1; hi_we = 1'b1; w_data = 32'hDEAD_BEEF;
    step();
    lo_we = 1'b0; hi_we = 1'b0;
    wait_done("busy_ignore");
    check("no_late_start", 65'(busy), 65'(0));

    lo_we = 1'b1; w_data = 32'h0000_1234;
    step();
    lo_we = 1'b0;
    check("mtlo_lo", 65'(lo), 65'(32'h1234));
    check("mtlo_hi_kept", 65'(hi), 65'(0));
    hi_we = 1'b1; w_data = 32'h0000_ABCD;
    step();
    hi_we = 1'b0;
    check("mthi_hi", 65'(hi), 65'(32'hABCD));

    // start wins over a simultaneous MTLO
    lo_we = 1'b1; w_data = 32'h5555_5555;
    launch(OP_MULTU, 32'd2, 32'd2, 1'b1);
    lo_we = 1'b0;
    check("start_wins_lo", 65'(lo), 65'(32'h1234));
    wait_done("start_wins");

    launch(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1); wait_done("div_zero_signed");

    // reset mid-operation
    launch(OP_DIV, 32'd100, 32'd3, 1'b0);
    repeat (14) step();
    rst = 1'b1;
    #1;
    check("abort_hi", 65'(hi), 65'(0));
    check("abort_lo", 65'(lo), 65'(0));
    check("abort_flags", 65'({busy, done, dz}), 65'(0));
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    check("no_done_after_rst", 65'(seen), 65'(0));
    check("queue_empty", 65'(exp_q.size()), 65'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Iterative multiply/divide unit for the MIPS single-cycle core. It sits beside the 32-bit ALU on the same A/B operand buses from the register file and implements MULT, MULTU, DIV and DIVU into HI/LO registers. Its HI/LO outputs feed the write-back mux that serves MFHI and MFLO. It uses a 32-iteration shift/add and restoring-subtract datapath, with a start/busy/done handshake that the control unit uses to stall the PC.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
ITER, 32, number of iteration cycles; must equal WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  launch an operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
A  input  32  multiplicand / dividend (rs)
B  input  32  multiplier / divisor (rt)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
w_data  input  32  MTHI/MTLO data
HI  output  32  HI register
LO  output  32  LO register
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when HI/LO are updated by an op
dz  output  1  sticky divide-by-zero flag for the last op

Behaviour:
- Reset: asynchronous and active-high. It is one clock domain. On reset, HI=0, LO=0, busy=0, done=0, dz=0, state=IDLE and the counter is 0. Reset asserted mid-operation aborts immediately, with no HI/LO update.
- States:
  - IDLE: start=1 at edge E0 captures op, |A| and |B| (signed ops take two's-complement magnitude), the sign bits and the B==0 flag. It then goes to CALC with counter=ITER-1, busy=1.
  - CALC: one iteration per edge, E1..E32. After the counter reaches 0, go to FIX.
    - Multiply: if acc[0] is set, the upper half gets +mcand, keeping carry; then shift the 65-bit value right by 1.
    - Divide: shift {rem,quo} left by 1. Trial-subtract the divisor; if the result is non-negative, keep it and set quo[0].
  - FIX (edge E33): apply sign correction and write HI/LO. Pulse done=1, drop busy=0 and return to IDLE. Results and done are visible in the cycle after E33, which is 33 cycles after the start edge.
- Sign rules:
  - MULT: the 64-bit product is negated if A[31]^B[31].
  - DIV: the quotient (LO) is negated if A[31]^B[31]; the remainder (HI) is negated if A[31].
  - Unsigned ops do no correction.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 by wrap.
- Divide by zero (B==0, DIV or DIVU):
  - Full latency is still taken.
  - Result: HI=A (original value), LO=0xFFFFFFFF, dz=1.
  - dz is cleared at the FIX of any later op, and by reset.
- Flag rules:
  - done is high for exactly one cycle per op.
  - busy is high from E0+ through E33-.
  - start while busy is ignored; captured operands are not disturbed.
- MTHI/MTLO: hi_we and lo_we write w_data at the edge only when state=IDLE and start=0. If start=1 in the same cycle, start wins and the writes are dropped. Writes while busy are dropped.
- A and B may change freely after E0.

Decomposition:
- Shared package `muldiv_pkg`:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state encoding: S_IDLE, S_CALC, S_FIX
  - ITER constant
- The control decoder imports the op encodings from the same package.
- No sub-module. The FSM, 65-bit accumulator and sign fix-up stay in one module.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse of 1 cycle, dz=0.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); busy high for exactly 33 cycles.
- DIVU 100/7 -> LO=0x0000000E, HI=0x00000002; DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=5, B=0 -> HI=0x00000005, LO=0xFFFFFFFF, dz=1. A following MULTU 2*3 -> LO=6, HI=0, dz=0.
- Start MULTU 3*4, then pulse start with DIVU 9/3 at cycle 10 and lo_we at cycle 12 -> both ignored; final LO=12, HI=0. MTLO 0x1234 in IDLE -> LO=0x1234 next cycle.
- Start DIV 100/3, assert rst at cycle 15 -> HI=LO=0, busy=0 and done=0 immediately. No done pulse appears afterwards.
